// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller: register offsets and default sizing.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gpio_pkg;

  localparam int GPIO_WIDTH_DEF = 8;
  localparam int GPIO_SYNC_DEF  = 2;

  // Register offsets as decoded from address[4:2]
  localparam logic [2:0] GPIO_DATA_IN    = 3'd0;
  localparam logic [2:0] GPIO_DATA_OUT   = 3'd1;
  localparam logic [2:0] GPIO_DIR        = 3'd2;
  localparam logic [2:0] GPIO_OUT_SET    = 3'd3;
  localparam logic [2:0] GPIO_OUT_CLR    = 3'd4;
  localparam logic [2:0] GPIO_RISE_EN    = 3'd5;
  localparam logic [2:0] GPIO_FALL_EN    = 3'd6;
  localparam logic [2:0] GPIO_IRQ_STATUS = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage input synchroniser with an edge-history flop; reports raw rise/fall per bit.
// Latency: async_i -> sync_o after SYNC_STAGES edges; rise_o/fall_o valid in the cycle sync_o changes.
// Backpressure: none; samples every cycle.
// Ports: clk, reset (sync, active-high), async_i (pads), sync_o (synchronised), rise_o/fall_o (unmasked edges).
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
      // prev tracks the synchronised value unconditionally, so a direction change
      // never leaves a stale history that could fake an edge later.
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: direction, atomic set/clear, synchronised inputs, W1C edge interrupts.
// Latency: writes take effect at the strobe edge; read_data registered at the read edge; irq one cycle after STATUS.
// Backpressure: none; single-cycle read/write strobes always accepted.
// Ports: clk, reset (sync, active-high), read/write strobes, address (bits [4:2] decoded),
//        write_data, read_data (registered), gpio (tristate pads), irq (level).
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH_DEF,
  parameter int SYNC_STAGES = GPIO_SYNC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      address,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  inout  logic [WIDTH-1:0] gpio,
  output logic             irq
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] din, rise, fall, hw_set, wd, rd_val;
  logic [2:0]       reg_sel;
  logic             unused_bus_bits;

  // Only address[4:2] and write_data[WIDTH-1:0] carry meaning.
  assign unused_bus_bits = ^{address, write_data};
  assign reg_sel         = address[4:2];
  assign wd              = write_data[WIDTH-1:0];

  gpio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .async_i(gpio),
    .sync_o (din),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Output pins never raise events, and disabled edges are simply dropped.
  assign hw_set = ((rise & rise_en_q) | (fall & fall_en_q)) & ~dir_q;

  always_comb begin
    dout_d    = dout_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    if (write) begin
      case (reg_sel)
        GPIO_DATA_OUT:   dout_d    = wd;
        GPIO_DIR:        dir_d     = wd;
        GPIO_OUT_SET:    dout_d    = dout_q | wd;
        GPIO_OUT_CLR:    dout_d    = dout_q & ~wd;
        GPIO_RISE_EN:    rise_en_d = wd;
        GPIO_FALL_EN:    fall_en_d = wd;
        GPIO_IRQ_STATUS: status_d  = status_q & ~wd;
        default:         ;
      endcase
    end
    // Applied after the W1C so a coincident hardware event keeps the bit set.
    status_d = status_d | hw_set;

    // Read mux sees pre-write register values.
    case (reg_sel)
      GPIO_DATA_IN:    rd_val = din;
      GPIO_DATA_OUT:   rd_val = dout_q;
      GPIO_DIR:        rd_val = dir_q;
      GPIO_RISE_EN:    rd_val = rise_en_q;
      GPIO_FALL_EN:    rd_val = fall_en_q;
      GPIO_IRQ_STATUS: rd_val = status_q;
      default:         rd_val = '0;
    endcase

    read_data_d = read_data_q;
    if (read) begin
      read_data_d              = '0;
      read_data_d[WIDTH-1:0]   = rd_val;
    end

    irq_d = |status_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q      <= '0;
      dir_q       <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      status_q    <= '0;
      read_data_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      dir_q       <= dir_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      status_q    <= status_d;
      read_data_q <= read_data_d;
      irq_q       <= irq_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign gpio[g] = dir_q[g] ? dout_q[g] : 1'bz;
  end

  assign read_data = read_data_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
module tb_gpio_ctrl;

  localparam int W = 5;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset, read, write;
  logic [31:0] address, write_data, read_data;
  wire  [W-1:0] gpio;
  logic        irq;

  logic [W-1:0] tb_oe  = '1;
  logic [W-1:0] tb_val = '0;
  logic [W-1:0] want_pad = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < W; g++) begin : g_tbpad
    assign gpio[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .gpio      (gpio),
    .irq       (irq)
  );

  // Reference model: architectural register values plus a history of pad samples.
  logic [W-1:0] m_dout, m_dir, m_ren, m_fen, m_stat;
  logic [31:0]  m_rdata;
  logic         m_irq;
  logic [W-1:0] pad_at [0:2047];
  int           cyc     = 0;
  int           rst_cyc = -1;
  int           n_chk   = 0;
  int           n_fail  = 0;

  // DATA_IN value visible after edge n: the pad sampled SYNC_STAGES-1 edges earlier,
  // or zero if that sample was at or before the last reset.
  function automatic logic [W-1:0] din_after(input int n);
    int k;
    k = n - (S - 1);
    if (k < 0 || k <= rst_cyc) return '0;
    return pad_at[k];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input bit rst, input bit rd, input bit wr,
                       input logic [2:0] a, input logic [31:0] wd);
    logic [W-1:0] nd, rel, cur, old, ev, w;
    logic [31:0]  addr;
    w   = wd[W-1:0];
    nd  = rst ? '0 : (wr && a == 3'd2) ? w : m_dir;
    // Pins being released are held by the bench at the value the DUT was driving.
    rel    = m_dir & ~nd;
    tb_val = (want_pad & ~rel) | (m_dout & rel);
    tb_oe  = ~(m_dir & nd);
    addr       = $urandom;
    addr[4:2]  = a;
    reset      = rst;
    read       = rd;
    write      = wr;
    address    = addr;
    write_data = wd;
    @(posedge clk);
    cyc++;
    pad_at[cyc] = (m_dir & m_dout) | (~m_dir & tb_val);
    if (rst) begin
      m_dout = '0; m_dir = '0; m_ren = '0; m_fen = '0; m_stat = '0;
      m_rdata = '0; m_irq = 1'b0; rst_cyc = cyc;
    end else begin
      cur = din_after(cyc - 1);
      old = din_after(cyc - 2);
      ev  = ((cur & ~old & m_ren) | (~cur & old & m_fen)) & ~m_dir;
      m_irq = |m_stat;
      if (rd) begin
        m_rdata = '0;
        case (a)
          3'd0: m_rdata[W-1:0] = cur;
          3'd1: m_rdata[W-1:0] = m_dout;
          3'd2: m_rdata[W-1:0] = m_dir;
          3'd5: m_rdata[W-1:0] = m_ren;
          3'd6: m_rdata[W-1:0] = m_fen;
          3'd7: m_rdata[W-1:0] = m_stat;
          default: ;
        endcase
      end
      if (wr) begin
        case (a)
          3'd1: m_dout = w;
          3'd2: m_dir  = w;
          3'd3: m_dout = m_dout | w;
          3'd4: m_dout = m_dout & ~w;
          3'd5: m_ren  = w;
          3'd6: m_fen  = w;
          3'd7: m_stat = m_stat & ~w;
          default: ;
        endcase
      end
      m_stat = m_stat | ev;
    end
    #1;
    tb_oe = ~m_dir;
    #1;
    reset = 1'b0; read = 1'b0; write = 1'b0;
    check_eq("read_data", read_data, m_rdata);
    check_eq("irq", {31'b0, irq}, {31'b0, m_irq});
    check_eq("pad_drive", {27'b0, gpio & m_dir}, {27'b0, m_dout & m_dir});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b0, 1'b1, a, d);
  endtask
  task automatic rd(input logic [2:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; write_data = '0;
    m_dout = '0; m_dir = '0; m_ren = '0; m_fen = '0; m_stat = '0; m_rdata = '0; m_irq = 1'b0;

    cycle(1'b1, 1'b0, 0, 3'd0, 32'h0);
    cycle(1'b1, 1'b0, 0, 3'd0, 32'h0);
    check_eq("reset_rdata", read_data, 32'h0);
    check_eq("reset_irq", {31'b0, irq}, 32'h0);

    // Direction and drive; pins 1,3 are inputs held low by the bench.
    want_pad = 5'h00;
    wr(3'd2, 32'h15);
    wr(3'd1, 32'h1F);
    check_eq("pads_high", {27'b0, gpio & 5'h15}, 32'h15);
    idle(3);
    rd(3'd0); check_eq("din_mixed", read_data, 32'h15);
    rd(3'd2); check_eq("dir_rd", read_data, 32'h15);
    rd(3'd7); check_eq("status_after_reset", read_data, 32'h0);

    // Atomic set/clear and upper-bit masking.
    wr(3'd4, 32'h04);
    wr(3'd3, 32'h02);
    rd(3'd1); check_eq("dout_setclr", read_data, 32'h1B);
    wr(3'd1, 32'hFFFF_FFE4);
    rd(3'd1); check_eq("dout_upper_masked", read_data, 32'h04);

    // Edge detection timing.
    wr(3'd2, 32'h0);
    want_pad = 5'h10;
    wr(3'd5, 32'h01);
    wr(3'd6, 32'h10);
    idle(4);
    want_pad = 5'h01;
    idle(1);
    idle(1);
    rd(3'd0); check_eq("din_latency", read_data, 32'h01);
    check_eq("irq_not_yet", {31'b0, irq}, 32'h0);
    rd(3'd7); check_eq("status_rise_fall", read_data, 32'h11);
    check_eq("irq_asserted", {31'b0, irq}, 32'h1);

    // W1C behaviour.
    wr(3'd7, 32'h01);
    rd(3'd7); check_eq("w1c_bit0", read_data, 32'h10);
    check_eq("irq_still_set", {31'b0, irq}, 32'h1);
    wr(3'd7, 32'h10);
    check_eq("irq_lags_clear", {31'b0, irq}, 32'h1);
    idle(1);
    check_eq("irq_dropped", {31'b0, irq}, 32'h0);
    want_pad = 5'h00; idle(3);
    want_pad = 5'h01; idle(1);
    want_pad = 5'h00; idle(1);
    want_pad = 5'h01; idle(1);
    idle(1);
    wr(3'd7, 32'h01);
    rd(3'd7); check_eq("set_beats_w1c", read_data, 32'h01);
    wr(3'd7, 32'h1F);
    idle(2);

    // Disabled edges are not latched; output pins never raise events.
    wr(3'd5, 32'h0);
    want_pad = 5'h03; idle(4);
    wr(3'd5, 32'h02);
    idle(2);
    rd(3'd7); check_eq("no_stale_event", read_data, 32'h0);
    wr(3'd6, 32'h12);
    wr(3'd2, 32'h02);
    wr(3'd3, 32'h02); idle(3);
    wr(3'd4, 32'h02); idle(3);
    rd(3'd7); check_eq("output_pin_no_event", read_data, 32'h0);

    // Reset while irq is pending and all pins drive.
    wr(3'd5, 32'h1F);
    want_pad = 5'h02; idle(3);
    want_pad = 5'h03; idle(4);
    check_eq("irq_before_reset", {31'b0, irq}, 32'h1);
    wr(3'd2, 32'h1F);
    rd(3'd2);
    check_eq("rdata_before_reset", read_data, 32'h1F);
    cycle(1'b1, 1'b0, 1'b1, 3'd7, 32'h0);
    check_eq("reset_irq_mid", {31'b0, irq}, 32'h0);
    check_eq("reset_rdata_mid", read_data, 32'h0);
    want_pad = 5'h00; idle(3);
    rd(3'd0); check_eq("pads_released", read_data, 32'h0);
    rd(3'd7); check_eq("status_cleared", read_data, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) want_pad = W'($urandom);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, 3'($urandom), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
